// File: rtl/ram_arbiter_if.sv
// Bundle of the three stage request/ready ports and the single-port RAM bus.
// The slave modport is the arbiter side. The master modport is the stages-plus-RAM side.
interface ram_arbiter_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8
);
    logic                  stage12_read;
    logic [ADDR_WIDTH-1:0] stage12_read_address;
    logic                  stage12_read_ready;
    logic [DATA_WIDTH-1:0] stage12_read_data_out;

    logic                  stage3_read;
    logic [ADDR_WIDTH-1:0] stage3_read_address;
    logic                  stage3_read_ready;
    logic [DATA_WIDTH-1:0] stage3_read_data_out;

    logic                  stage5_write;
    logic [ADDR_WIDTH-1:0] stage5_write_address;
    logic [DATA_WIDTH-1:0] stage5_write_data;
    logic                  stage5_write_ready;

    logic                  mem_write_enable;
    logic [ADDR_WIDTH-1:0] mem_address;
    logic [DATA_WIDTH-1:0] mem_data_in;
    logic [DATA_WIDTH-1:0] mem_data_out;

    modport slave (
        input  stage12_read, stage12_read_address,
        output stage12_read_ready, stage12_read_data_out,
        input  stage3_read, stage3_read_address,
        output stage3_read_ready, stage3_read_data_out,
        input  stage5_write, stage5_write_address, stage5_write_data,
        output stage5_write_ready,
        output mem_write_enable, mem_address, mem_data_in,
        input  mem_data_out
    );

    modport master (
        output stage12_read, stage12_read_address,
        input  stage12_read_ready, stage12_read_data_out,
        output stage3_read, stage3_read_address,
        input  stage3_read_ready, stage3_read_data_out,
        output stage5_write, stage5_write_address, stage5_write_data,
        input  stage5_write_ready,
        input  mem_write_enable, mem_address, mem_data_in,
        output mem_data_out
    );
endinterface

// File: rtl/ram_arbiter.sv
// Fixed-priority, four-phase-handshake responder that shares one synchronous RAM
// among the stage12 fetch, stage3 operand-read and stage5 store ports.
module ram_arbiter #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8
) (
    input  logic         ram_clk,
    input  logic         rst,
    ram_arbiter_if.slave bus
);

    typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE, DONE} state_t;
    typedef enum logic [1:0] {GNT_NONE, GNT_S12, GNT_S3, GNT_S5} grant_t;

    state_t                state_q, state_d;
    grant_t                grant_q, grant_d;
    logic                  mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_din_q, mem_din_d;
    logic                  s12_ready_q, s12_ready_d;
    logic [DATA_WIDTH-1:0] s12_data_q, s12_data_d;
    logic                  s3_ready_q, s3_ready_d;
    logic [DATA_WIDTH-1:0] s3_data_q, s3_data_d;
    logic                  s5_ready_q, s5_ready_d;
    logic                  granted_req;

    always_comb begin
        // NOTE: every next-state value defaults to its current flop value first,
        // so no branch can leave a signal unassigned and infer a latch.
        state_d     = state_q;
        grant_d     = grant_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_din_d   = mem_din_q;
        s12_ready_d = s12_ready_q;
        s12_data_d  = s12_data_q;
        s3_ready_d  = s3_ready_q;
        s3_data_d   = s3_data_q;
        s5_ready_d  = s5_ready_q;

        unique case (grant_q)
            GNT_S12: granted_req = bus.stage12_read;
            GNT_S3:  granted_req = bus.stage3_read;
            GNT_S5:  granted_req = bus.stage5_write;
            default: granted_req = 1'b0;
        endcase

        unique case (state_q)
            IDLE: begin
                if (bus.stage5_write) begin
                    grant_d    = GNT_S5;
                    mem_addr_d = bus.stage5_write_address;
                    mem_din_d  = bus.stage5_write_data;
                    mem_we_d   = 1'b1;
                    state_d    = ACCESS;
                end else if (bus.stage3_read) begin
                    grant_d    = GNT_S3;
                    mem_addr_d = bus.stage3_read_address;
                    mem_we_d   = 1'b0;
                    state_d    = ACCESS;
                end else if (bus.stage12_read) begin
                    grant_d    = GNT_S12;
                    mem_addr_d = bus.stage12_read_address;
                    mem_we_d   = 1'b0;
                    state_d    = ACCESS;
                end
            end
            ACCESS: begin
                // The RAM samples the address and any write on this edge; keep it to one write cycle.
                mem_we_d = 1'b0;
                state_d  = CAPTURE;
            end
            CAPTURE: begin
                unique case (grant_q)
                    GNT_S12: begin
                        s12_data_d  = bus.mem_data_out;
                        s12_ready_d = 1'b1;
                    end
                    GNT_S3: begin
                        s3_data_d  = bus.mem_data_out;
                        s3_ready_d = 1'b1;
                    end
                    GNT_S5:  s5_ready_d = 1'b1;
                    default: ;
                endcase
                state_d = DONE;
            end
            DONE: begin
                if (!granted_req) begin
                    s12_ready_d = 1'b0;
                    s3_ready_d  = 1'b0;
                    s5_ready_d  = 1'b0;
                    grant_d     = GNT_NONE;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the values from before the edge, whatever order the statements run in.
    always_ff @(posedge ram_clk) begin
        if (rst) begin
            state_q     <= IDLE;
            grant_q     <= GNT_NONE;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_din_q   <= '0;
            s12_ready_q <= 1'b0;
            s12_data_q  <= '0;
            s3_ready_q  <= 1'b0;
            s3_data_q   <= '0;
            s5_ready_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_din_q   <= mem_din_d;
            s12_ready_q <= s12_ready_d;
            s12_data_q  <= s12_data_d;
            s3_ready_q  <= s3_ready_d;
            s3_data_q   <= s3_data_d;
            s5_ready_q  <= s5_ready_d;
        end
    end

    assign bus.mem_write_enable      = mem_we_q;
    assign bus.mem_address           = mem_addr_q;
    assign bus.mem_data_in           = mem_din_q;
    assign bus.stage12_read_ready    = s12_ready_q;
    assign bus.stage12_read_data_out = s12_data_q;
    assign bus.stage3_read_ready     = s3_ready_q;
    assign bus.stage3_read_data_out  = s3_data_q;
    assign bus.stage5_write_ready    = s5_ready_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter: directed stimulus pushes expected completions,
// and a negedge monitor pops and checks each rising ready against them.
module tb_ram_arbiter;

    localparam int P12 = 0;
    localparam int P3  = 1;
    localparam int P5  = 2;

    typedef struct packed {
        logic [1:0] port;
        logic [7:0] data;
    } exp_t;

    logic ram_clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;
    exp_t sb_q[$];
    int   we_total = 0;
    logic p12_q = 1'b0, p3_q = 1'b0, p5_q = 1'b0;
    logic [7:0] ram_mem [0:65535];
    logic        preload_en = 1'b0;
    logic [15:0] preload_addr = '0;
    logic [7:0]  preload_data = '0;

    ram_arbiter_if #(.ADDR_WIDTH(16), .DATA_WIDTH(8)) bus ();

    ram_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(8)) dut (
        .ram_clk (ram_clk),
        .rst     (rst),
        .bus     (bus)
    );

    always #5 ram_clk = ~ram_clk;

    // Behavioural single-port RAM with registered read and a backdoor preload port.
    always @(posedge ram_clk) begin
        if (preload_en)
            ram_mem[preload_addr] <= preload_data;
        else if (bus.mem_write_enable)
            ram_mem[bus.mem_address] <= bus.mem_data_in;
        bus.mem_data_out <= ram_mem[bus.mem_address];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic sb_pop(input int port, input logic [7:0] data);
        exp_t e;
        if (sb_q.size() == 0) begin
            check("spurious_ready", sb_q.size(), 1);
        end else begin
            e = sb_q.pop_front();
            check("ready_port_order", port, e.port);
            if (port != P5) check("read_data", data, e.data);
        end
    endtask

    always @(negedge ram_clk) begin
        if (bus.stage5_write_ready && !p5_q) sb_pop(P5, 8'h00);
        if (bus.stage3_read_ready && !p3_q)  sb_pop(P3, bus.stage3_read_data_out);
        if (bus.stage12_read_ready && !p12_q) sb_pop(P12, bus.stage12_read_data_out);
        p5_q  <= bus.stage5_write_ready;
        p3_q  <= bus.stage3_read_ready;
        p12_q <= bus.stage12_read_ready;
        if (bus.mem_write_enable) we_total <= we_total + 1;
    end

    function automatic logic ready_of(input int p);
        case (p)
            P12:     return bus.stage12_read_ready;
            P3:      return bus.stage3_read_ready;
            default: return bus.stage5_write_ready;
        endcase
    endfunction

    task automatic set_req(input int p, input logic v, input logic [15:0] a);
        case (p)
            P12: begin bus.stage12_read = v; bus.stage12_read_address = a; end
            P3:  begin bus.stage3_read  = v; bus.stage3_read_address  = a; end
            default: begin bus.stage5_write = v; bus.stage5_write_address = a; end
        endcase
    endtask

    task automatic preload(input logic [15:0] a, input logic [7:0] d);
        @(negedge ram_clk);
        preload_en = 1'b1; preload_addr = a; preload_data = d;
        @(negedge ram_clk);
        preload_en = 1'b0;
    endtask

    // Read with exact-latency checks; optionally changes the address one cycle after the request.
    task automatic do_read(input int p, input logic [15:0] a, input logic [7:0] exp,
                           input logic chg, input logic [15:0] a2);
        @(negedge ram_clk);
        set_req(p, 1'b1, a);
        sb_q.push_back('{port: 2'(p), data: exp});
        @(negedge ram_clk);
        check("ready_low_n", ready_of(p), 1'b0);
        if (chg) set_req(p, 1'b1, a2);
        @(negedge ram_clk);
        check("ready_low_n1", ready_of(p), 1'b0);
        @(negedge ram_clk);
        check("ready_high_n2", ready_of(p), 1'b1);
        set_req(p, 1'b0, a);
        @(negedge ram_clk);
        check("ready_release", ready_of(p), 1'b0);
    endtask

    task automatic do_write(input logic [15:0] a, input logic [7:0] d);
        int w0;
        w0 = we_total;
        @(negedge ram_clk);
        bus.stage5_write_data = d;
        set_req(P5, 1'b1, a);
        sb_q.push_back('{port: 2'(P5), data: 8'h00});
        repeat (3) @(negedge ram_clk);
        check("write_ready_n2", bus.stage5_write_ready, 1'b1);
        check("write_one_we_cycle", we_total - w0, 1);
        check("write_ram_content", ram_mem[a], d);
        set_req(P5, 1'b0, a);
        @(negedge ram_clk);
        check("write_release", bus.stage5_write_ready, 1'b0);
        check("write_no_extra_we", we_total - w0, 1);
    endtask

    // Each port drops its request on the first negedge its ready is seen high.
    task automatic drain();
        logic pending;
        pending = 1'b1;
        for (int i = 0; i < 60 && pending; i++) begin
            @(negedge ram_clk);
            if (bus.stage5_write_ready) bus.stage5_write = 1'b0;
            if (bus.stage3_read_ready)  bus.stage3_read  = 1'b0;
            if (bus.stage12_read_ready) bus.stage12_read = 1'b0;
            pending = bus.stage5_write | bus.stage3_read | bus.stage12_read |
                      bus.stage5_write_ready | bus.stage3_read_ready | bus.stage12_read_ready;
        end
        check("drain_timeout", pending, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        bus.stage12_read = 1'b0; bus.stage12_read_address = '0;
        bus.stage3_read  = 1'b0; bus.stage3_read_address  = '0;
        bus.stage5_write = 1'b0; bus.stage5_write_address = '0;
        bus.stage5_write_data = '0;

        preload(16'h0000, 8'h02);
        preload(16'h0004, 8'h11);
        preload(16'h0008, 8'h22);
        preload(16'h0010, 8'h01);

        // Reset held with every request high; stage5 must win once reset drops.
        @(negedge ram_clk);
        bus.stage5_write_data = 8'h77;
        set_req(P5, 1'b1, 16'h0100);
        set_req(P3, 1'b1, 16'h0010);
        set_req(P12, 1'b1, 16'h0000);
        repeat (2) begin
            @(negedge ram_clk);
            check("rst_ready", {bus.stage5_write_ready, bus.stage3_read_ready, bus.stage12_read_ready}, 3'b000);
            check("rst_we", bus.mem_write_enable, 1'b0);
            check("rst_addr", bus.mem_address, 16'h0000);
        end
        check("rst_data_out", {bus.stage3_read_data_out, bus.stage12_read_data_out}, 16'h0000);
        sb_q.push_back('{port: 2'(P5),  data: 8'h00});
        sb_q.push_back('{port: 2'(P3),  data: 8'h01});
        sb_q.push_back('{port: 2'(P12), data: 8'h02});
        rst = 1'b0;
        @(negedge ram_clk);
        check("first_grant_addr", bus.mem_address, 16'h0100);
        check("first_grant_we", bus.mem_write_enable, 1'b1);
        drain();

        do_read(P12, 16'h0010, 8'h01, 1'b0, 16'h0000);

        do_write(16'h0200, 8'h5A);
        do_read(P3, 16'h0200, 8'h5A, 1'b0, 16'h0000);

        @(negedge ram_clk);
        bus.stage5_write_data = 8'hA5;
        set_req(P5, 1'b1, 16'h0300);
        set_req(P3, 1'b1, 16'h0300);
        set_req(P12, 1'b1, 16'h0000);
        sb_q.push_back('{port: 2'(P5),  data: 8'h00});
        sb_q.push_back('{port: 2'(P3),  data: 8'hA5});
        sb_q.push_back('{port: 2'(P12), data: 8'h02});
        drain();
        check("simul_ram_content", ram_mem[16'h0300], 8'hA5);

        do_read(P12, 16'h0004, 8'h11, 1'b1, 16'h0008);

        // Reset lands on the CAPTURE edge of a stage3 read: no ready may ever appear.
        @(negedge ram_clk);
        set_req(P3, 1'b1, 16'h0010);
        @(negedge ram_clk);
        @(negedge ram_clk);
        rst = 1'b1;
        set_req(P3, 1'b0, 16'h0010);
        @(negedge ram_clk);
        rst = 1'b0;
        check("rst_capture_ready", bus.stage3_read_ready, 1'b0);
        check("rst_capture_data", bus.stage3_read_data_out, 8'h00);
        repeat (3) @(negedge ram_clk);
        check("rst_capture_still_low", bus.stage3_read_ready, 1'b0);
        do_read(P3, 16'h0200, 8'h5A, 1'b0, 16'h0000);

        do_write(16'hFFFF, 8'hC3);
        do_read(P12, 16'hFFFF, 8'hC3, 1'b0, 16'h0000);

        repeat (2) @(negedge ram_clk);
        check("scoreboard_empty", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
